// File: rtl/shared_llq_pkg.sv
// Shared helpers for the shared_llq linked-list multi-queue FIFO:
// pointer/select width helpers and the reset free-chain link function.
package shared_llq_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Reset free chain: every slot links to its successor; the last link is never followed.
    function automatic int reset_link(input int slot, input int depth);
        return (slot + 1) % depth;
    endfunction

endpackage

// File: rtl/llq_free_list.sv
// Linked free list for shared_llq: allocates from fhead, appends released
// slots at ftail, and tracks how many entries are free.
module llq_free_list
    import shared_llq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = ptr_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc,
    input  logic                 rel,
    input  logic [PTR_WIDTH-1:0] rel_ptr,
    output logic [PTR_WIDTH-1:0] fhead,
    output logic [PTR_WIDTH:0]   free_count
);
    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [PTR_WIDTH:0]   cnt_t;

    ptr_t fnext [DEPTH];
    ptr_t ftail;

    always_ff @(posedge clk) begin
        if (rst) begin
            fhead      <= '0;
            ftail      <= ptr_t'(DEPTH - 1);
            free_count <= cnt_t'(DEPTH);
            // NOTE: this link array is reset because the free chain must exist from the first
            // cycle; the data store is deliberately left unreset since no entry is live yet.
            for (int i = 0; i < DEPTH; i++) fnext[i] <= ptr_t'(reset_link(i, DEPTH));
        end else if (alloc && rel) begin
            if (free_count == cnt_t'(1)) begin
                // The only free slot leaves while the popped slot arrives: it becomes the whole list.
                fhead <= rel_ptr;
                ftail <= rel_ptr;
            end else begin
                fhead        <= fnext[fhead];
                fnext[ftail] <= rel_ptr;
                ftail        <= rel_ptr;
            end
        end else if (alloc) begin
            fhead      <= fnext[fhead];
            free_count <= free_count - cnt_t'(1);
        end else if (rel) begin
            if (free_count == '0) fhead <= rel_ptr;
            else                  fnext[ftail] <= rel_ptr;
            ftail      <= rel_ptr;
            free_count <= free_count + cnt_t'(1);
        end
    end

endmodule

// File: rtl/shared_llq.sv
// NUM_QUEUES linked-list queues sharing one DEPTH-entry store, with per-queue caps and
// registered pop data/error strobes. Define SHARED_LLQ_ASSERT_EN to enable ghost checks.
module shared_llq
    import shared_llq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 4,
    parameter int NUM_QUEUES = 2,
    parameter int QCAP       = DEPTH,
    parameter int PTR_WIDTH  = ptr_width(DEPTH),
    parameter int SEL_WIDTH  = sel_width(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [SEL_WIDTH-1:0]  push_sel,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  pop,
    input  logic [SEL_WIDTH-1:0]  pop_sel,
    output logic [WIDTH-1:0]      data_out,
    output logic                  data_out_vld,
    output logic                  push_err,
    output logic                  pop_err,
    output logic                  full,
    output logic [NUM_QUEUES-1:0] empty,
    output logic [NUM_QUEUES-1:0] qfull,
    output logic [PTR_WIDTH:0]    free_count
);
    localparam int SEL_SPAN = 1 << SEL_WIDTH;
    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [PTR_WIDTH:0]   cnt_t;

    logic [WIDTH-1:0] data_mem [DEPTH];
    ptr_t             next_mem [DEPTH];
    ptr_t             head     [NUM_QUEUES];
    ptr_t             tail     [NUM_QUEUES];
    cnt_t             count    [NUM_QUEUES];

    ptr_t                  fhead;
    ptr_t                  push_tail, pop_head;
    cnt_t                  push_cnt;
    logic                  push_ok, pop_ok;
    logic [NUM_QUEUES-1:0] push_hit, pop_hit;
    logic [SEL_SPAN-1:0]   empty_x, qfull_x;

    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            empty[q] = (count[q] == '0);
            qfull[q] = (count[q] == cnt_t'(QCAP));
        end
    end

    assign full = (free_count == '0);

    // Selects beyond NUM_QUEUES read as empty and capped, so they are always rejected.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        empty_x   = '1;
        qfull_x   = '1;
        push_tail = '0;
        push_cnt  = '0;
        pop_head  = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            empty_x[q] = empty[q];
            qfull_x[q] = qfull[q];
            if (push_sel == SEL_WIDTH'(q)) begin
                push_tail = tail[q];
                push_cnt  = count[q];
            end
            if (pop_sel == SEL_WIDTH'(q)) pop_head = head[q];
        end
        push_ok = push && !full && !qfull_x[push_sel];
        pop_ok  = pop && !empty_x[pop_sel];
        for (int q = 0; q < NUM_QUEUES; q++) begin
            push_hit[q] = push_ok && (push_sel == SEL_WIDTH'(q));
            pop_hit[q]  = pop_ok && (pop_sel == SEL_WIDTH'(q));
        end
    end

    llq_free_list #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_free (
        .clk       (clk),
        .rst       (rst),
        .alloc     (push_ok),
        .rel       (pop_ok),
        .rel_ptr   (pop_head),
        .fhead     (fhead),
        .free_count(free_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out     <= '0;
            data_out_vld <= 1'b0;
            push_err     <= 1'b0;
            pop_err      <= 1'b0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                head[q]  <= '0;
                tail[q]  <= '0;
                count[q] <= '0;
            end
        end else begin
            data_out_vld <= pop_ok;
            push_err     <= push && !push_ok;
            pop_err      <= pop && !pop_ok;
            if (pop_ok) data_out <= data_mem[pop_head];
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (pop_hit[q]) head[q] <= next_mem[head[q]];
                if (push_hit[q]) begin
                    tail[q] <= fhead;
                    // Pushed slot becomes head when the queue is, or is about to become, empty.
                    if (count[q] == '0 || (pop_hit[q] && count[q] == cnt_t'(1))) head[q] <= fhead;
                end
                count[q] <= count[q] + cnt_t'(push_hit[q]) - cnt_t'(pop_hit[q]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_mem[fhead] <= data_in;
            if (push_cnt != '0) next_mem[push_tail] <= fhead;
        end
    end

`ifdef SHARED_LLQ_ASSERT_EN
    cnt_t prev_count [NUM_QUEUES];
    ptr_t prev_head  [NUM_QUEUES];
    ptr_t prev_tail  [NUM_QUEUES];
    cnt_t prev_free;
    logic prev_quiet;

    always_ff @(posedge clk) begin
        prev_count <= count;
        prev_head  <= head;
        prev_tail  <= tail;
        prev_free  <= free_count;
        prev_quiet <= !rst && !push_ok && !pop_ok;
    end

    always @(posedge clk) begin
        if (!rst) begin : ghost
            int   total;
            int   seen [DEPTH];
            ptr_t p;
            total = int'(free_count);
            for (int i = 0; i < DEPTH; i++) seen[i] = 0;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                total += int'(count[q]);
                assert (empty[q] == (count[q] == '0)) else $error("empty/count disagree q%0d", q);
                p = head[q];
                for (int k = 0; k < int'(count[q]); k++) begin
                    seen[p]++;
                    if (k == int'(count[q]) - 1) assert (p == tail[q]) else $error("queue %0d walk misses tail", q);
                    p = next_mem[p];
                end
                if (prev_quiet) begin
                    assert (count[q] == prev_count[q] && head[q] == prev_head[q] && tail[q] == prev_tail[q])
                        else $error("queue %0d changed without an accepted request", q);
                end
            end
            assert (total == DEPTH) else $error("free_count + counts = %0d", total);
            p = u_free.fhead;
            for (int k = 0; k < int'(free_count); k++) begin
                seen[p]++;
                if (k == int'(free_count) - 1) assert (p == u_free.ftail) else $error("free walk misses ftail");
                p = u_free.fnext[p];
            end
            for (int i = 0; i < DEPTH; i++) assert (seen[i] == 1) else $error("slot %0d on %0d lists", i, seen[i]);
            if (prev_quiet) assert (free_count == prev_free) else $error("free_count changed while idle");
        end
    end
`endif

endmodule

// File: tb/tb_shared_llq.sv
// Directed bench for shared_llq (WIDTH=4, DEPTH=4, NUM_QUEUES=2, QCAP=3) with a
// scoreboard of expected pop data checked by an independent output monitor.
`timescale 1ns/1ps
module tb_shared_llq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic [0:0] push_sel = '0;
    logic [3:0] data_in = '0;
    logic       pop = 1'b0;
    logic [0:0] pop_sel = '0;
    logic [3:0] data_out;
    logic       data_out_vld, push_err, pop_err, full;
    logic [1:0] empty, qfull;
    logic [2:0] free_count;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];

    shared_llq #(.WIDTH(4), .DEPTH(4), .NUM_QUEUES(2), .QCAP(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_sel    (push_sel),
        .data_in     (data_in),
        .pop         (pop),
        .pop_sel     (pop_sel),
        .data_out    (data_out),
        .data_out_vld(data_out_vld),
        .push_err    (push_err),
        .pop_err     (pop_err),
        .full        (full),
        .empty       (empty),
        .qfull       (qfull),
        .free_count  (free_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expected pop.
    always @(negedge clk) begin
        if (data_out_vld) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe: data_out_vld high with data 0x%0h, no pop outstanding", data_out);
            end else begin
                check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycle(input logic p, input logic ps, input logic [3:0] d, input logic q, input logic qs);
        push = p; push_sel = ps; data_in = d; pop = q; pop_sel = qs;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic expect_pop(input logic [3:0] d);
        exp_q.push_back(d);
    endtask

    task automatic check_status(input string tag, input logic [1:0] e, input logic f,
                                input logic [1:0] qf, input logic [2:0] fc);
        check({tag, " empty"}, 32'(empty), 32'(e));
        check({tag, " full"}, 32'(full), 32'(f));
        check({tag, " qfull"}, 32'(qfull), 32'(qf));
        check({tag, " free_count"}, 32'(free_count), 32'(fc));
    endtask

    task automatic check_err(input string tag, input logic pe, input logic qe);
        check({tag, " push_err"}, 32'(push_err), 32'(pe));
        check({tag, " pop_err"}, 32'(pop_err), 32'(qe));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cycle(0, 0, 4'h0, 0, 0);
        check_status("reset", 2'b11, 0, 2'b00, 3'd4);
        check("reset data_out", 32'(data_out), 32'h0);
        check("reset vld", 32'(data_out_vld), 32'h0);
        check_err("reset", 0, 0);

        // Basic ordering across two queues.
        cycle(1, 0, 4'hA, 0, 0);
        cycle(1, 0, 4'hB, 0, 0);
        cycle(1, 1, 4'hC, 0, 0);
        check_status("fill3", 2'b00, 0, 2'b00, 3'd1);
        expect_pop(4'hA); cycle(0, 0, 4'h0, 1, 0);
        expect_pop(4'hB); cycle(0, 0, 4'h0, 1, 0);
        check_status("q0 drained", 2'b01, 0, 2'b00, 3'd3);
        expect_pop(4'hC); cycle(0, 0, 4'h0, 1, 1);
        cycle(0, 0, 4'h0, 0, 0);
        check("hold data_out", 32'(data_out), 32'hC);
        check("hold vld", 32'(data_out_vld), 32'h0);
        check_status("basic end", 2'b11, 0, 2'b00, 3'd4);

        // Per-queue cap, global full, and a push blocked despite a concurrent pop.
        cycle(1, 0, 4'h1, 0, 0);
        cycle(1, 0, 4'h2, 0, 0);
        cycle(1, 0, 4'h3, 0, 0);
        check_err("cap fill", 0, 0);
        check_status("cap fill", 2'b10, 0, 2'b01, 3'd1);
        cycle(1, 0, 4'h4, 0, 0);
        check_err("cap reject", 1, 0);
        check_status("cap reject", 2'b10, 0, 2'b01, 3'd1);
        cycle(1, 1, 4'h5, 0, 0);
        check_err("full push", 0, 0);
        check_status("full", 2'b00, 1, 2'b01, 3'd0);
        expect_pop(4'h1); cycle(1, 1, 4'h6, 1, 0);
        check_err("full push+pop", 1, 0);
        check_status("full push+pop", 2'b00, 0, 2'b00, 3'd1);
        expect_pop(4'h2); cycle(0, 0, 4'h0, 1, 0);
        expect_pop(4'h3); cycle(0, 0, 4'h0, 1, 0);
        expect_pop(4'h5); cycle(0, 0, 4'h0, 1, 1);
        check_status("cap end", 2'b11, 0, 2'b00, 3'd4);

        // Last free slot allocated while the popped slot is freed.
        cycle(1, 0, 4'h7, 0, 0);
        cycle(1, 0, 4'h8, 0, 0);
        cycle(1, 0, 4'h9, 0, 0);
        expect_pop(4'h7); cycle(1, 1, 4'hA, 1, 0);
        check_err("last slot swap", 0, 0);
        check_status("last slot swap", 2'b00, 0, 2'b00, 3'd1);
        cycle(1, 1, 4'hB, 0, 0);
        check_status("refill", 2'b00, 1, 2'b00, 3'd0);
        expect_pop(4'h8); cycle(0, 0, 4'h0, 1, 0);
        expect_pop(4'h9); cycle(0, 0, 4'h0, 1, 0);
        expect_pop(4'hA); cycle(0, 0, 4'h0, 1, 1);
        expect_pop(4'hB); cycle(0, 0, 4'h0, 1, 1);
        check_status("swap end", 2'b11, 0, 2'b00, 3'd4);

        // Same-queue push and pop with a single resident entry.
        cycle(1, 0, 4'h5, 0, 0);
        expect_pop(4'h5); cycle(1, 0, 4'h6, 1, 0);
        check_err("count1 push+pop", 0, 0);
        check_status("count1 push+pop", 2'b10, 0, 2'b00, 3'd3);
        expect_pop(4'h6); cycle(0, 0, 4'h0, 1, 0);
        check_status("count1 end", 2'b11, 0, 2'b00, 3'd4);

        // No same-cycle bypass: pop of empty queue rejected while push lands.
        cycle(1, 1, 4'hD, 1, 1);
        check_err("no bypass", 0, 1);
        check_status("no bypass", 2'b01, 0, 2'b00, 3'd3);
        expect_pop(4'hD); cycle(0, 0, 4'h0, 1, 1);
        check_err("bypass followup", 0, 0);
        cycle(0, 0, 4'h0, 1, 0);
        check_err("pop empty q0", 0, 1);
        cycle(0, 0, 4'h0, 0, 0);
        check_err("err strobe clears", 0, 0);

        // Reset mid-operation with a concurrent push.
        cycle(1, 0, 4'h1, 0, 0);
        cycle(1, 0, 4'h2, 0, 0);
        cycle(1, 0, 4'h3, 0, 0);
        check_status("pre-rst", 2'b10, 0, 2'b01, 3'd1);
        rst = 1'b1;
        cycle(1, 0, 4'h4, 0, 0);
        check_status("mid rst", 2'b11, 0, 2'b00, 3'd4);
        check("mid rst data_out", 32'(data_out), 32'h0);
        check("mid rst vld", 32'(data_out_vld), 32'h0);
        check_err("mid rst", 0, 0);
        rst = 1'b0;
        cycle(0, 0, 4'h0, 1, 0);
        check_err("post rst pop", 0, 1);
        cycle(1, 0, 4'hE, 0, 0);
        expect_pop(4'hE); cycle(0, 0, 4'h0, 1, 0);
        cycle(0, 0, 4'h0, 0, 0);
        check_status("final", 2'b11, 0, 2'b00, 3'd4);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_llq.md
# shared_llq

Parametrised multi-queue FIFO: NUM_QUEUES logical queues share one DEPTH-entry data store, threaded as linked lists with a linked free list. It is the next-generation linked-list shared FIFO, adding explicit accept/reject reporting, per-queue occupancy caps, a registered output-valid strobe and a free-slot count. It sits between producers/consumers and is the design-under-test for the refinement-proof harness.

## Interface

**Parameters**
- WIDTH, 4, data bits per entry.
- DEPTH, 4, shared entries; power of two, ≥2.
- NUM_QUEUES, 2, logical queues; ≥1.
- QCAP, DEPTH, maximum entries any single queue may hold; 1..DEPTH.
- PTR_WIDTH, $clog2(DEPTH), derived.
- SEL_WIDTH, max(1,$clog2(NUM_QUEUES)), derived.

**Ports**
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- push  in  1  push request.
- push_sel  in  SEL_WIDTH  target queue for push.
- data_in  in  WIDTH  push data.
- pop  in  1  pop request.
- pop_sel  in  SEL_WIDTH  source queue for pop.
- data_out  out  WIDTH  popped data, registered.
- data_out_vld  out  1  one-cycle strobe, data_out valid.
- push_err  out  1  registered; previous push was rejected.
- pop_err  out  1  registered; previous pop was rejected.
- full  out  1  no free entries.
- empty  out  NUM_QUEUES  per-queue empty.
- qfull  out  NUM_QUEUES  per-queue count == QCAP.
- free_count  out  PTR_WIDTH+1  free entries, 0..DEPTH.

## Operation

- State:
  - data_mem[DEPTH] and next_mem[DEPTH].
  - Per queue: head, tail and count (PTR_WIDTH+1 bits).
  - Free list: fhead, ftail and free_count.
- Reset:
  - Free list chains 0→1→…→DEPTH-1, with fhead=0, ftail=DEPTH-1 and free_count=DEPTH.
  - All queue counts are 0.
  - Outputs: data_out=0, data_out_vld=0, push_err=0, pop_err=0, full=0, empty=all ones, qfull=0.
- Push acceptance:
  - Accepted iff push, push_sel<NUM_QUEUES, ~full and ~qfull[push_sel].
  - All terms use pre-edge state. A simultaneous pop does not unblock a full or capped push.
  - Accepted push: allocates fhead, writes data_in to it, and links it at the queue tail. If the queue was empty, head=tail=slot.
- Pop acceptance:
  - Accepted iff pop, pop_sel<NUM_QUEUES and ~empty[pop_sel].
  - Accepted pop: registers data_mem[head] to data_out, advances head=next_mem[head], and appends the old head to the free-list tail.
- Rejection: a rejected request changes no state, and raises push_err or pop_err for one cycle.
- Simultaneous accepted push and pop:
  - Both complete in the same cycle, on the same or different queues.
  - Same queue with count==1: the new head is the pushed slot.
  - When free_count==1 and that slot is allocated while the popped slot is freed: the freed slot becomes both fhead and ftail.
- Counts:
  - count[q] += acc_push(q) − acc_pop(q).
  - free_count += acc_pop − acc_push.
  - Neither wraps; the acceptance rules guarantee this.
- Status: full, empty and qfull are combinational from the registered counts.

## Timing

- Pop latency is 1. The accepted pop at edge N drives data_out/data_out_vld valid after edge N; data_out_vld is high for exactly one cycle per pop.
- data_out holds its last value while data_out_vld=0.
- Status outputs reflect an accepted push or pop after the same edge.
- Pushed data is poppable in the next cycle (push at edge N, pop at edge N+1).
- No same-cycle push-to-pop bypass: a pop of an empty queue with a concurrent push is rejected.
- rst mid-operation discards all contents, and outputs take reset values after that edge.

## Configuration

- SHARED_LLQ_ASSERT_EN is the one compile-time feature.
- Defined: the block includes ghost checks as immediate assertions on every cycle out of reset:
  - free_count + Σcount == DEPTH.
  - empty[q] ⇔ count[q]==0.
  - The free list and every queue, walked from its head, have lengths equal to their counts.
  - No entry appears on two lists.
  - A rejected request leaves state unchanged.
- Undefined: the assertion logic is absent, and functional behaviour is identical.

## Structure

- Package shared_llq_pkg holds the ptr_t and cnt_t typedef widths helper, a max(1,clog2) function, and the reset-chain constant function.
- Sub-module llq_free_list holds fhead, ftail, free_count and the free-list next links, with alloc/release ports. It is instantiated once.
- The queue heads, tails and counts, plus data_mem, live in shared_llq.

## Test plan

All scenarios use WIDTH=4, DEPTH=4, NUM_QUEUES=2, QCAP=3.

- Reset, then idle: empty=2'b11, full=0, free_count=4, data_out=0, no strobes.
- Push 0xA, 0xB to q0 and 0xC to q1, then pop q0, q0, q1: data_out=0xA, 0xB, 0xC, each with one data_out_vld cycle; end state free_count=4, empty=11.
- Push 4 entries to q0: the 4th is rejected, push_err=1, qfull[0]=1, free_count=1. Then push to q1: accepted, full=1. A further push with a concurrent q0 pop: push rejected, pop accepted, free_count=1.
- q0 holds 1 entry (0x5); same cycle push q0 0x6 and pop q0: data_out=0x5, count stays 1; next pop gives 0x6.
- Pop empty q1 with a concurrent push to q1: pop_err=1 and the push is accepted; the next-cycle pop returns the pushed data.
- Fill q0 with 3 entries, assert rst with a concurrent push: all outputs return to reset values and the push is discarded.
